gci_std_kmc_fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one gci_std_kmc_sync_fifo write port among REQ_N requesters.

---
 rtl/gci_std_kmc_arb_pkg.sv | 17 +
 rtl/gci_std_kmc_rr_pick.sv | 35 +++
 rtl/gci_std_kmc_fifo_wr_arbiter.sv | 141 ++++++++++++++
 tb/tb_gci_std_kmc_fifo_wr_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gci_std_kmc_arb_pkg.sv
// Shared definitions for the gci_std_kmc FIFO write arbiter.
// Contents:
//   STATE_W      width of the debug state output
//   arb_state_e  FSM encoding (IDLE=0, RUN=1, STALL=2, LOCK=3)
// The LOCK encoding is reserved and only reached when GCI_STD_KMC_WR_ARB_LOCK_EN is defined.
package gci_std_kmc_arb_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StStall = 2'd2,
    StLock  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/gci_std_kmc_rr_pick.sv
// Combinational rotate-priority picker.
// Finds the first set bit of iVALID at or after index iPTR, wrapping REQ_N-1 -> 0.
// Ports:
//   iVALID  [REQ_N]  candidate request bits
//   iPTR    [REQ_W]  highest-priority index this cycle
//   oFOUND           any candidate set
//   oIDX    [REQ_W]  chosen index (0 when none)
//   oONEHOT [REQ_N]  chosen index as one-hot (0 when none)
module gci_std_kmc_rr_pick #(
  parameter int unsigned REQ_N = 4,
  parameter int unsigned REQ_W = 2
) (
  input  logic [REQ_N-1:0] iVALID,
  input  logic [REQ_W-1:0] iPTR,
  output logic             oFOUND,
  output logic [REQ_W-1:0] oIDX,
  output logic [REQ_N-1:0] oONEHOT
);

  always_comb begin
    int unsigned j;
    j      = 0;
    oFOUND = 1'b0;
    oIDX   = '0;
    for (int unsigned i = 0; i < REQ_N; i++) begin
      j = (int'(iPTR) + i) % REQ_N;
      if (!oFOUND && iVALID[j]) begin
        oFOUND = 1'b1;
        oIDX   = REQ_W'(j);
      end
    end
    oONEHOT = oFOUND ? (REQ_N'(1) << oIDX) : '0;
  end

endmodule

// File: rtl/gci_std_kmc_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one gci_std_kmc_sync_fifo write port among REQ_N requesters.
// At most one requester is acked per cycle; its data is registered into the FIFO write port,
// giving one clock of latency and up to one write per clock. Grants are throttled on FIFO
// full, and on almost-full while a write is still in flight, so the FIFO never overflows.
// Optional feature macro: GCI_STD_KMC_WR_ARB_LOCK_EN adds iREQ_LOCK and the LOCK state, in
// which a granted requester holding its lock keeps the write port until lock or valid drops.
// Ports:
//   iCLOCK, iRESET_SYNC         clock, synchronous active-high reset
//   iREMOVE                     flush; forwarded registered to oFIFO_REMOVE
//   iREQ_VALID/iREQ_DATA        per-requester request and data (requester i at [i*N +: N])
//   iREQ_LOCK                   per-requester lock (only with the macro)
//   oREQ_ACK                    one-hot combinational ack; acked data is taken at this edge
//   oFIFO_WR_EN/oFIFO_WR_DATA   registered FIFO write
//   iFIFO_WR_FULL/_ALMOST_FULL  FIFO write-side status
//   oGRANT_IDX                  index of the last granted requester
//   oSTATE                      FSM state for debug
module gci_std_kmc_fifo_wr_arbiter
  import gci_std_kmc_arb_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned REQ_N = 4,
  parameter int unsigned REQ_W = 2
) (
  input  logic                 iCLOCK,
  input  logic                 iRESET_SYNC,
  input  logic                 iREMOVE,
  input  logic [REQ_N-1:0]     iREQ_VALID,
  input  logic [REQ_N*N-1:0]   iREQ_DATA,
`ifdef GCI_STD_KMC_WR_ARB_LOCK_EN
  input  logic [REQ_N-1:0]     iREQ_LOCK,
`endif
  output logic [REQ_N-1:0]     oREQ_ACK,
  output logic                 oFIFO_REMOVE,
  output logic                 oFIFO_WR_EN,
  output logic [N-1:0]         oFIFO_WR_DATA,
  input  logic                 iFIFO_WR_FULL,
  input  logic                 iFIFO_WR_ALMOST_FULL,
  output logic [REQ_W-1:0]     oGRANT_IDX,
  output logic [STATE_W-1:0]   oSTATE
);

  arb_state_e       state_q, state_d;
  logic [REQ_W-1:0] rr_q, rr_d;
  logic [REQ_W-1:0] gidx_q, gidx_d;
  logic             wr_en_q, wr_en_d;
  logic [N-1:0]     wr_data_q, wr_data_d;
  logic             remove_q;

  logic             space_ok;
  logic             lock_hold;
  logic             grant;
  logic             grant_lock;
  logic [REQ_N-1:0] cand_valid;
  logic             pick_found;
  logic [REQ_W-1:0] pick_idx;
  logic [REQ_N-1:0] pick_onehot;

  // Candidate set: everyone, or only the lock holder while its lock is held.
  always_comb begin
    // A write still in the output register lands next edge, so almost-full is already full.
    space_ok   = !iFIFO_WR_FULL && !(iFIFO_WR_ALMOST_FULL && wr_en_q);
    lock_hold  = 1'b0;
    cand_valid = iREQ_VALID;
`ifdef GCI_STD_KMC_WR_ARB_LOCK_EN
    lock_hold = (state_q == StLock) && iREQ_VALID[gidx_q] && iREQ_LOCK[gidx_q];
    if (lock_hold) cand_valid = iREQ_VALID & (REQ_N'(1) << gidx_q);
`endif
  end

  gci_std_kmc_rr_pick #(
    .REQ_N (REQ_N),
    .REQ_W (REQ_W)
  ) u_pick (
    .iVALID  (cand_valid),
    .iPTR    (rr_q),
    .oFOUND  (pick_found),
    .oIDX    (pick_idx),
    .oONEHOT (pick_onehot)
  );

  always_comb begin
    grant      = space_ok && pick_found && !iREMOVE && !iRESET_SYNC;
    grant_lock = 1'b0;
`ifdef GCI_STD_KMC_WR_ARB_LOCK_EN
    grant_lock = grant && iREQ_LOCK[pick_idx];
`endif
    oREQ_ACK  = grant ? pick_onehot : '0;
    wr_en_d   = grant;
    wr_data_d = wr_data_q;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    state_d   = state_q;

    if (grant) begin
      wr_data_d = iREQ_DATA[pick_idx*N +: N];
      gidx_d    = pick_idx;
      // A locked grant keeps the pointer so round-robin resumes where it left off.
      if (!grant_lock) begin
        rr_d = (pick_idx == REQ_W'(REQ_N - 1)) ? '0 : pick_idx + REQ_W'(1);
      end
    end

    if (iREMOVE) begin
      state_d = StIdle;
      rr_d    = '0;
    end else if (!(|iREQ_VALID)) begin
      state_d = StIdle;
    end else if (grant) begin
      state_d = grant_lock ? StLock : StRun;
    end else if (lock_hold) begin
      state_d = StLock;
    end else begin
      state_d = StStall;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      gidx_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      remove_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gidx_q    <= gidx_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      remove_q  <= iREMOVE;
    end
  end

  assign oFIFO_REMOVE  = remove_q;
  assign oFIFO_WR_EN   = wr_en_q;
  assign oFIFO_WR_DATA = wr_data_q;
  assign oGRANT_IDX    = gidx_q;
  assign oSTATE        = state_q;

endmodule

// File: tb/tb_gci_std_kmc_fifo_wr_arbiter.sv
// Bench for gci_std_kmc_fifo_wr_arbiter (N=16, REQ_N=4) with a behavioural 4-deep FIFO model.
module tb_gci_std_kmc_fifo_wr_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, rm;
  logic [3:0]  valid;
  logic [63:0] data;
  logic [3:0]  ack;
  logic        fifo_rm, wr_en, full, af;
  logic [15:0] wr_data;
  logic [1:0]  gidx, state;
`ifdef GCI_STD_KMC_WR_ARB_LOCK_EN
  logic [3:0]  lock = 4'b0000;
`endif

  logic [15:0] d [4];
  logic [15:0] sb [$];
  int          total = 0;
  int          bad = 0;
  int          cnt = 0;
  int          nwr = 0;
  logic        rd = 1'b0;

  always #5 clk = ~clk;
  always_comb data = {d[3], d[2], d[1], d[0]};

  gci_std_kmc_fifo_wr_arbiter #(
    .N     (16),
    .REQ_N (4),
    .REQ_W (2)
  ) dut (
    .iCLOCK               (clk),
    .iRESET_SYNC          (rst),
    .iREMOVE              (rm),
    .iREQ_VALID           (valid),
    .iREQ_DATA            (data),
`ifdef GCI_STD_KMC_WR_ARB_LOCK_EN
    .iREQ_LOCK            (lock),
`endif
    .oREQ_ACK             (ack),
    .oFIFO_REMOVE         (fifo_rm),
    .oFIFO_WR_EN          (wr_en),
    .oFIFO_WR_DATA        (wr_data),
    .iFIFO_WR_FULL        (full),
    .iFIFO_WR_ALMOST_FULL (af),
    .oGRANT_IDX           (gidx),
    .oSTATE               (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample ack, push the acked data, advance the FIFO model, check the write.
  task automatic tick(output logic [3:0] a);
    logic w;
    #1;
    a = ack;
    w = wr_en;
    chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
    for (int i = 0; i < 4; i++) if (ack[i]) sb.push_back(d[i]);
    if (w) begin
      nwr++;
      chk("no_overflow", 32'(cnt >= DEPTH && !rd), 32'd0);
    end
    @(posedge clk);
    cnt = cnt + (w ? 1 : 0) - ((rd && cnt > 0) ? 1 : 0);
    if (cnt > DEPTH) cnt = DEPTH;
    #1;
    if (wr_en) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk("wr_data", 32'(wr_data), 32'(sb.pop_front()));
    end
  endtask

  task automatic model_status();
    full = (cnt == DEPTH);
    af   = (cnt >= DEPTH - 1);
  endtask

  task automatic reset_pulse();
    logic [3:0] a;
    rst = 1'b1; rm = 1'b0; valid = '0; full = 1'b0; af = 1'b0; rd = 1'b0;
    tick(a);
    rst = 1'b0;
    sb.delete();
    cnt = 0;
  endtask

  typedef struct {
    logic       rst;
    logic       rm;
    logic [3:0] valid;
    logic       full;
    logic       af;
    logic [3:0] ack;
    logic       wr;
    logic [1:0] st;
    logic [1:0] gi;
    logic       frm;
  } vec_t;

  vec_t       vecs [18];
  logic [3:0] a;
  int         nack;

  initial begin
    d[0] = 16'h1234; d[1] = 16'h5678; d[2] = 16'hA5A5; d[3] = 16'hC3C3;
    //          rst rm valid  full af  ack    wr st gi frm
    vecs[0]  = '{0, 0, 4'hF, 0, 0, 4'b0001, 1, 1, 0, 0};
    vecs[1]  = '{0, 0, 4'hF, 0, 0, 4'b0010, 1, 1, 1, 0};
    vecs[2]  = '{0, 0, 4'hF, 0, 0, 4'b0100, 1, 1, 2, 0};
    vecs[3]  = '{0, 0, 4'hF, 0, 0, 4'b1000, 1, 1, 3, 0};
    vecs[4]  = '{0, 0, 4'hF, 0, 0, 4'b0001, 1, 1, 0, 0};
    vecs[5]  = '{0, 0, 4'h4, 0, 0, 4'b0100, 1, 1, 2, 0};
    vecs[6]  = '{0, 0, 4'h0, 0, 0, 4'b0000, 0, 0, 2, 0};
    vecs[7]  = '{0, 0, 4'h3, 1, 0, 4'b0000, 0, 2, 2, 0};
    vecs[8]  = '{0, 0, 4'h3, 0, 1, 4'b0001, 1, 1, 0, 0};
    vecs[9]  = '{0, 0, 4'h3, 0, 1, 4'b0000, 0, 2, 0, 0};
    vecs[10] = '{0, 0, 4'h3, 0, 1, 4'b0010, 1, 1, 1, 0};
    vecs[11] = '{0, 1, 4'h3, 0, 0, 4'b0000, 0, 0, 1, 1};
    vecs[12] = '{0, 0, 4'hF, 0, 0, 4'b0001, 1, 1, 0, 0};
    vecs[13] = '{0, 0, 4'h8, 0, 0, 4'b1000, 1, 1, 3, 0};
    vecs[14] = '{0, 0, 4'h4, 0, 0, 4'b0100, 1, 1, 2, 0};
    vecs[15] = '{1, 1, 4'hF, 0, 0, 4'b0000, 0, 0, 0, 0};
    vecs[16] = '{0, 0, 4'hF, 0, 0, 4'b0001, 1, 1, 0, 0};
    vecs[17] = '{0, 0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0};

    // Reset with every requester asking: nothing may be acked or written.
    rst = 1'b1; rm = 1'b1; valid = 4'hF; full = 1'b0; af = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_fifo_rm", 32'(fifo_rm), 32'd0);
    chk("rst_gidx", 32'(gidx), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    rst = 1'b0; rm = 1'b0; valid = '0;

    // Table phase: FIFO status driven directly from the vectors.
    rd = 1'b1;
    for (int k = 0; k < 18; k++) begin
      rst = vecs[k].rst; rm = vecs[k].rm; valid = vecs[k].valid;
      full = vecs[k].full; af = vecs[k].af;
      tick(a);
      chk($sformatf("v%0d_ack", k), 32'(a), 32'(vecs[k].ack));
      chk($sformatf("v%0d_wr_en", k), 32'(wr_en), 32'(vecs[k].wr));
      chk($sformatf("v%0d_state", k), 32'(state), 32'(vecs[k].st));
      chk($sformatf("v%0d_gidx", k), 32'(gidx), 32'(vecs[k].gi));
      chk($sformatf("v%0d_fifo_rm", k), 32'(fifo_rm), 32'(vecs[k].frm));
    end
    rst = 1'b0; rm = 1'b0;

    // Fill: req0 streams 0x0001.. into a FIFO that is never read.
    reset_pulse();
    d[0] = 16'h0001; nack = 0; nwr = 0;
    for (int k = 0; k < 12; k++) begin
      valid = 4'b0001; model_status();
      tick(a);
      if (a[0]) begin nack++; d[0] = d[0] + 16'h1; end
    end
    chk("fill_acks", 32'(nack), 32'd4);
    chk("fill_writes", 32'(nwr), 32'd4);
    chk("fill_cnt", 32'(cnt), 32'(DEPTH));
    chk("fill_state", 32'(state), 32'd2);

    // One read from a full FIFO frees exactly one slot.
    rd = 1'b1; model_status();
    tick(a);
    chk("read_cycle_ack", 32'(a), 32'd0);
    rd = 1'b0; nack = 0;
    for (int k = 0; k < 8; k++) begin
      model_status();
      tick(a);
      if (a[0]) begin nack++; d[0] = d[0] + 16'h1; end
    end
    chk("one_slot_acks", 32'(nack), 32'd1);
    chk("one_slot_cnt", 32'(cnt), 32'(DEPTH));
    chk("one_slot_state", 32'(state), 32'd2);

    // Drained FIFO, all requesters valid: strict rotation 0,1,2,3,...
    reset_pulse();
    rd = 1'b1;
    for (int k = 0; k < 12; k++) begin
      valid = 4'hF; model_status();
      tick(a);
      chk($sformatf("rot%0d_ack", k), 32'(a), 32'(4'b0001 << (k % 4)));
    end

`ifdef GCI_STD_KMC_WR_ARB_LOCK_EN
    // req1 holds the lock; req3 waits until it is released.
    reset_pulse();
    rd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid = 4'b1010; lock = 4'b0010; model_status();
      tick(a);
      chk($sformatf("lock%0d_ack", k), 32'(a), 32'b0010);
    end
    chk("lock_state", 32'(state), 32'd3);
    valid = 4'b1000; lock = 4'b0000; model_status();
    tick(a);
    chk("unlock_ack", 32'(a), 32'b1000);
`endif

    valid = '0;
    tick(a);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
